// File: rtl/omsp_alu_x_pkg.sv
// Shared openMSP430 ALU definitions: operation codes, width selects and
// FSM state encodings used by both the decoder and the execution ALU.
package omsp_alu_x_pkg;

  typedef enum logic [4:0] {
    OP_MOV  = 5'd0,
    OP_ADD  = 5'd1,
    OP_ADDC = 5'd2,
    OP_SUB  = 5'd3,
    OP_SUBC = 5'd4,
    OP_CMP  = 5'd5,
    OP_DADD = 5'd6,
    OP_BIT  = 5'd7,
    OP_BIC  = 5'd8,
    OP_BIS  = 5'd9,
    OP_XOR  = 5'd10,
    OP_AND  = 5'd11,
    OP_RRC  = 5'd12,
    OP_RRA  = 5'd13,
    OP_RLA  = 5'd14,
    OP_RRU  = 5'd15,
    OP_SWPB = 5'd16,
    OP_SXT  = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    WID_8  = 2'd0,
    WID_16 = 2'd1,
    WID_20 = 2'd2
  } wid_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DADD  = 2'd2,
    ST_FIN   = 2'd3
  } alu_state_e;

  // Iteration counter width: covers SHIFT_MAX up to 8 and five DADD nibbles.
  localparam int CNT_W = 3;

  function automatic logic is_rotate(alu_op_e op);
    return (op == OP_RRC) || (op == OP_RRA) || (op == OP_RLA) || (op == OP_RRU);
  endfunction

endpackage

// File: rtl/omsp_bcd_nibble.sv
// One BCD digit adder: a + b + ci, adjusted by 6 when the raw sum reaches 10.
// Bit 4 of the 5-bit result is the decimal carry into the next digit.
module omsp_bcd_nibble (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [4:0] sum
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
  // Non-BCD digits take the same +6 path; the 5-bit result simply wraps.
  assign sum = (raw >= 5'd10) ? raw + 5'd6 : raw;

endmodule

// File: rtl/omsp_alu_x.sv
// Multi-cycle openMSP430 ALU with 8/16/20-bit widths and serial rotates.
// Define OMSP_ALU_DADD_EN for nibble-serial DADD; otherwise DADD acts as ADDC.
module omsp_alu_x
  import omsp_alu_x_pkg::*;
#(
  parameter int  DW        = 16,
  parameter int  SHIFT_MAX = 4,
  localparam int SCW       = $clog2(SHIFT_MAX)
) (
  input  logic           mclk,
  input  logic           puc_rst_n,
  input  logic           start,
  input  logic           flush,
  input  logic [4:0]     alu_op,
  input  logic           inst_bw,
  input  logic           inst_aw,
  input  logic [SCW-1:0] shift_cnt,
  input  logic [DW-1:0]  op_src,
  input  logic [DW-1:0]  op_dst,
  input  logic [3:0]     status,
  output logic           busy,
  output logic           done,
  output logic [DW-1:0]  alu_out,
  output logic [3:0]     alu_stat,
  output logic [3:0]     alu_stat_wr
);

`ifdef OMSP_ALU_DADD_EN
  localparam bit DADD_SER = 1'b1;
`else
  localparam bit DADD_SER = 1'b0;
`endif

  alu_state_e       state_q, state_d;
  alu_op_e          op_q, cur_op;
  wid_e             w_q, cur_w;
  logic [DW-1:0]    src_q, dst_q, work_q;
  logic [CNT_W-1:0] cnt_q, tot_q, in_tot, cur_cnt, cur_tot;
  logic             carry_q;

  logic [DW-1:0]    cur_src, cur_dst, work_in, mask, topm;
  logic [DW-1:0]    a, s, b, res, next_work;
  logic [DW:0]      sum;
  logic [3:0]       cur_stat;
  logic             cur_c, cin, next_c, c_f, v_f, n_f, z_f, c_notz, wr;
  logic             iter_st, accept, step_en, last, fire;
  logic             a_msb, b_msb, r_msb;

  // Operand selection: live inputs while idle, captured state while iterating.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    iter_st = (state_q == ST_SHIFT) || (state_q == ST_DADD);
    accept  = !iter_st && start;

    if (iter_st) begin
      cur_op = op_q;
      cur_w  = w_q;
    end else begin
      cur_op = alu_op_e'(alu_op);
      if (!DADD_SER && cur_op == OP_DADD) cur_op = OP_ADDC;
      if (inst_bw)                      cur_w = WID_8;
      else if (inst_aw && DW == 20)     cur_w = WID_20;
      else                              cur_w = WID_16;
    end

    case (cur_w)
      WID_8:   mask = DW'(8'hFF);
      WID_20:  mask = DW'(20'hFFFFF);
      default: mask = DW'(16'hFFFF);
    endcase
    topm = mask ^ (mask >> 1);

    in_tot = '0;
    if (is_rotate(cur_op)) in_tot = CNT_W'(shift_cnt);
    else if (cur_op == OP_DADD) begin
      case (cur_w)
        WID_8:   in_tot = CNT_W'(1);
        WID_20:  in_tot = CNT_W'(4);
        default: in_tot = CNT_W'(3);
      endcase
    end

    cur_src  = iter_st ? src_q : op_src;
    cur_dst  = iter_st ? dst_q : op_dst;
    cur_cnt  = iter_st ? cnt_q : '0;
    cur_tot  = iter_st ? tot_q : in_tot;
    cur_stat = iter_st ? {3'b000, carry_q} : status;
    cur_c    = cur_stat[0];
    work_in  = iter_st ? work_q : ((cur_op == OP_DADD) ? '0 : (op_src & mask));
    last     = (cur_cnt == cur_tot);
    step_en  = !flush && (accept || iter_st);
    fire     = step_en && last;
  end

`ifdef OMSP_ALU_DADD_EN
  logic [3:0] dig_a, dig_b;
  logic [4:0] bcd_sum;

  assign dig_a = 4'(cur_dst >> {cur_cnt, 2'b00});
  assign dig_b = 4'(cur_src >> {cur_cnt, 2'b00});

  omsp_bcd_nibble u_bcd (
    .a   (dig_a),
    .b   (dig_b),
    .ci  (cur_c),
    .sum (bcd_sum)
  );
`endif

  // One iteration of the datapath plus the flags it would produce if final.
  always_comb begin
    a     = cur_dst & mask;
    s     = cur_src & mask;
    b     = (cur_op inside {OP_SUB, OP_SUBC, OP_CMP}) ? (~s & mask) : s;
    cin   = (cur_op == OP_ADD) ? 1'b0 :
            (cur_op inside {OP_SUB, OP_CMP}) ? 1'b1 : cur_c;
    sum   = {1'b0, a} + {1'b0, b} + {{DW{1'b0}}, cin};
    a_msb = |(a & topm);
    b_msb = |(b & topm);

    res       = s;
    next_work = work_in;
    next_c    = cur_c;
    c_f       = cur_stat[0];
    v_f       = cur_stat[3];
    c_notz    = 1'b0;
    wr        = 1'b1;

    case (cur_op)
      OP_MOV: wr = 1'b0;
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        res = sum[DW-1:0] & mask;
        c_f = |(sum & {topm, 1'b0});
        v_f = (a_msb == b_msb) && (|(res & topm) != a_msb);
      end
`ifdef OMSP_ALU_DADD_EN
      OP_DADD: begin
        next_c    = bcd_sum[4];
        next_work = work_in | (DW'(bcd_sum[3:0]) << {cur_cnt, 2'b00});
        res       = next_work;
        c_f       = next_c;
        v_f       = 1'b0;
      end
`endif
      OP_BIT, OP_AND: begin
        res    = a & s;
        v_f    = 1'b0;
        c_notz = 1'b1;
      end
      OP_BIC: begin
        res = a & ~s;
        wr  = 1'b0;
      end
      OP_BIS: begin
        res = a | s;
        wr  = 1'b0;
      end
      OP_XOR: begin
        res    = a ^ s;
        v_f    = a_msb & |(s & topm);
        c_notz = 1'b1;
      end
      OP_RRC, OP_RRA, OP_RRU, OP_RLA: begin
        if (cur_op == OP_RLA) begin
          next_c    = |(work_in & topm);
          next_work = (work_in << 1) & mask;
        end else begin
          next_c    = work_in[0];
          next_work = work_in >> 1;
          if (cur_op == OP_RRC && cur_c) next_work = next_work | topm;
          if (cur_op == OP_RRA)          next_work = next_work | (work_in & topm);
        end
        res = next_work;
        c_f = next_c;
        v_f = 1'b0;
      end
      OP_SWPB: begin
        res = DW'({cur_src[7:0], cur_src[15:8]});
        wr  = 1'b0;
      end
      OP_SXT: begin
        res    = {{(DW-8){cur_src[7]}}, cur_src[7:0]};
        v_f    = 1'b0;
        c_notz = 1'b1;
      end
      default: wr = 1'b0;
    endcase

    r_msb = |(res & topm);
    n_f   = r_msb;
    z_f   = ((res & mask) == '0);
    if (c_notz) c_f = !z_f;
  end

  always_comb begin
    state_d = state_q;
    if (flush) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE, ST_FIN: begin
          if (!start)    state_d = ST_IDLE;
          else if (last) state_d = ST_FIN;
          else           state_d = (cur_op == OP_DADD) ? ST_DADD : ST_SHIFT;
        end
        default: if (last) state_d = ST_FIN;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_q     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      alu_out     <= '0;
      alu_stat    <= '0;
      alu_stat_wr <= '0;
    end else begin
      state_q     <= state_d;
      busy        <= (state_d == ST_SHIFT) || (state_d == ST_DADD);
      done        <= fire;
      alu_stat_wr <= (fire && wr) ? 4'b1111 : 4'b0000;
      if (fire) begin
        alu_out  <= res;
        alu_stat <= {v_f, n_f, z_f, c_f};
      end
    end
  end

  // Captured operation context and iteration state.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      op_q    <= OP_MOV;
      w_q     <= WID_16;
      src_q   <= '0;
      dst_q   <= '0;
      tot_q   <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept && !flush) begin
        op_q  <= cur_op;
        w_q   <= cur_w;
        src_q <= op_src;
        dst_q <= op_dst;
        tot_q <= in_tot;
      end
      if (step_en) begin
        work_q  <= next_work;
        carry_q <= next_c;
        cnt_q   <= cur_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_omsp_alu_x.sv
// Directed self-checking bench for omsp_alu_x (DW=20, SHIFT_MAX=4).
// Expected values adapt to whether OMSP_ALU_DADD_EN is defined.
module tb_omsp_alu_x;
  import omsp_alu_x_pkg::*;

  localparam int DW        = 20;
  localparam int SHIFT_MAX = 4;
  localparam int SCW       = 2;

  logic           mclk = 1'b0;
  logic           puc_rst_n = 1'b1;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  logic [4:0]     alu_op = '0;
  logic           inst_bw = 1'b0;
  logic           inst_aw = 1'b0;
  logic [SCW-1:0] shift_cnt = '0;
  logic [DW-1:0]  op_src = '0;
  logic [DW-1:0]  op_dst = '0;
  logic [3:0]     status = '0;
  logic           busy, done;
  logic [DW-1:0]  alu_out;
  logic [3:0]     alu_stat, alu_stat_wr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 mclk = ~mclk;

  omsp_alu_x #(.DW(DW), .SHIFT_MAX(SHIFT_MAX)) dut (
    .mclk        (mclk),
    .puc_rst_n   (puc_rst_n),
    .start       (start),
    .flush       (flush),
    .alu_op      (alu_op),
    .inst_bw     (inst_bw),
    .inst_aw     (inst_aw),
    .shift_cnt   (shift_cnt),
    .op_src      (op_src),
    .op_dst      (op_dst),
    .status      (status),
    .busy        (busy),
    .done        (done),
    .alu_out     (alu_out),
    .alu_stat    (alu_stat),
    .alu_stat_wr (alu_stat_wr)
  );

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic launch(alu_op_e op, logic bw, logic aw, int cnt,
                        logic [DW-1:0] src, logic [DW-1:0] dst, logic [3:0] st);
    alu_op    = op;
    inst_bw   = bw;
    inst_aw   = aw;
    shift_cnt = SCW'(cnt);
    op_src    = src;
    op_dst    = dst;
    status    = st;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Waits out lat-1 busy cycles, then checks the done cycle.
  task automatic run_vec(string tag, alu_op_e op, logic bw, logic aw, int cnt,
                         logic [DW-1:0] src, logic [DW-1:0] dst, logic [3:0] st,
                         int lat, logic [DW-1:0] exp_out, logic chk_flags,
                         logic [3:0] exp_flags, logic [3:0] exp_wr);
    tick();
    launch(op, bw, aw, cnt, src, dst, st);
    for (int c = 1; c < lat; c++) begin
      check($sformatf("%s.busy@%0d", tag, c), {busy, done}, 2'b10);
      tick();
    end
    check({tag, ".done"}, {busy, done}, 2'b01);
    check({tag, ".out"}, alu_out, exp_out);
    check({tag, ".wr"}, alu_stat_wr, exp_wr);
    if (chk_flags) check({tag, ".stat"}, alu_stat, exp_flags);
  endtask

  initial begin
    int seen;

    #1 puc_rst_n = 1'b0;
    #3;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.out", alu_out, 0);
    check("rst.stat", alu_stat, 0);
    check("rst.wr", alu_stat_wr, 0);
    tick();
    tick();
    #2 puc_rst_n = 1'b1;
    tick();

    // Signed overflow on word ADD, then the result holds after done drops.
    launch(OP_ADD, 0, 0, 0, 20'h07FFF, 20'h00001, 4'b0000);
    check("add.done", {busy, done}, 2'b01);
    check("add.out", alu_out, 20'h08000);
    check("add.stat", alu_stat, 4'b1100);
    check("add.wr", alu_stat_wr, 4'b1111);
    tick();
    check("add.done_clr", done, 0);
    check("add.wr_clr", alu_stat_wr, 0);
    check("add.hold", alu_out, 20'h08000);

    run_vec("rra4", OP_RRA, 0, 0, 3, 20'h08010, 20'h0, 4'b0000, 4, 20'h0F801, 1, 4'b0100, 4'hF);

`ifdef OMSP_ALU_DADD_EN
    run_vec("daddb", OP_DADD, 1, 0, 0, 20'h00099, 20'h00001, 4'b0001, 2, 20'h00001, 1, 4'b0001, 4'hF);
    run_vec("daddw", OP_DADD, 0, 0, 0, 20'h05678, 20'h01234, 4'b0000, 4, 20'h06912, 1, 4'b0000, 4'hF);
    run_vec("dadd_nbcd", OP_DADD, 1, 0, 0, 20'h0000A, 20'h00005, 4'b0000, 2, 20'h00015, 1, 4'b0000, 4'hF);
`else
    run_vec("daddb", OP_DADD, 1, 0, 0, 20'h00099, 20'h00001, 4'b0001, 1, 20'h0009B, 1, 4'b0100, 4'hF);
    run_vec("daddw", OP_DADD, 0, 0, 0, 20'h05678, 20'h01234, 4'b0000, 1, 20'h068AC, 1, 4'b0000, 4'hF);
    run_vec("dadd_nbcd", OP_DADD, 1, 0, 0, 20'h0000A, 20'h00005, 4'b0000, 1, 20'h0000F, 1, 4'b0000, 4'hF);
`endif

    // 20-bit SUB, then a byte MOV launched in the SUB's done cycle.
    run_vec("sub20", OP_SUB, 0, 1, 0, 20'h00001, 20'h00000, 4'b0000, 1, 20'hFFFFF, 1, 4'b0100, 4'hF);
    launch(OP_MOV, 1, 0, 0, 20'h12345, 20'h0, 4'b0000);
    check("movb.done", {busy, done}, 2'b01);
    check("movb.out", alu_out, 20'h00045);
    check("movb.wr", alu_stat_wr, 0);

    // Flush mid-rotate; a start during busy must be ignored.
    tick();
    launch(OP_RRC, 0, 0, 3, 20'h0F0F0, 20'h0, 4'b0001);
    check("flush.busy1", {busy, done}, 2'b10);
    alu_op  = OP_MOV;
    op_src  = 20'hABCDE;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("flush.busy2", {busy, done}, 2'b10);
    flush   = 1'b1;
    tick();
    flush   = 1'b0;
    check("flush.busy3", {busy, done}, 2'b00);
    check("flush.hold", alu_out, 20'h00045);
    seen = 0;
    repeat (5) begin
      tick();
      seen += int'(done);
    end
    check("flush.no_done", seen, 0);
    check("flush.hold2", alu_out, 20'h00045);

    // Flush wins over a same-cycle start.
    alu_op = OP_ADD;
    op_src = 20'h00001;
    op_dst = 20'h00001;
    start  = 1'b1;
    flush  = 1'b1;
    tick();
    start  = 1'b0;
    flush  = 1'b0;
    check("flushpri.done", {busy, done}, 2'b00);
    tick();
    check("flushpri.hold", {done, alu_out}, {1'b0, 20'h00045});

    run_vec("andz", OP_AND, 0, 0, 0, 20'h000F0, 20'h00F0F, 4'b0000, 1, 20'h00000, 1, 4'b0010, 4'hF);
    run_vec("xorv", OP_XOR, 0, 0, 0, 20'h08000, 20'h08001, 4'b0000, 1, 20'h00001, 1, 4'b1001, 4'hF);
    run_vec("cmpb", OP_CMP, 1, 0, 0, 20'h00001, 20'h00001, 4'b0000, 1, 20'h00000, 1, 4'b0011, 4'hF);
    run_vec("subcb", OP_SUBC, 1, 0, 0, 20'h00001, 20'h00080, 4'b0001, 1, 20'h0007F, 1, 4'b1001, 4'hF);
    run_vec("addc20", OP_ADDC, 0, 1, 0, 20'hFFFFF, 20'h00001, 4'b0000, 1, 20'h00000, 1, 4'b0011, 4'hF);
    run_vec("rlab", OP_RLA, 1, 0, 0, 20'h00081, 20'h0, 4'b0000, 1, 20'h00002, 1, 4'b0001, 4'hF);
    run_vec("rrc2", OP_RRC, 0, 0, 1, 20'h00001, 20'h0, 4'b0001, 2, 20'h0C000, 1, 4'b0100, 4'hF);
    run_vec("rru3", OP_RRU, 0, 0, 2, 20'h08005, 20'h0, 4'b0000, 3, 20'h01000, 1, 4'b0001, 4'hF);
    run_vec("bic", OP_BIC, 0, 0, 0, 20'h000FF, 20'h01234, 4'b0000, 1, 20'h01200, 0, 4'b0000, 4'h0);
    run_vec("swpb", OP_SWPB, 0, 0, 0, 20'h12345, 20'h0, 4'b0000, 1, 20'h04523, 0, 4'b0000, 4'h0);
    run_vec("sxt", OP_SXT, 0, 0, 0, 20'h00080, 20'h0, 4'b0000, 1, 20'hFFF80, 0, 4'b0000, 4'hF);

    // Asynchronous reset while a word DADD is in flight.
    tick();
    launch(OP_DADD, 0, 0, 0, 20'h05678, 20'h01234, 4'b0000);
    #2 puc_rst_n = 1'b0;
    #1;
    check("arst.busy", busy, 0);
    check("arst.done", done, 0);
    check("arst.out", alu_out, 0);
    check("arst.stat", alu_stat, 0);
    check("arst.wr", alu_stat_wr, 0);
    tick();
    #2 puc_rst_n = 1'b1;
    tick();
    check("arst.idle", {busy, done}, 2'b00);
    launch(OP_ADD, 0, 0, 0, 20'h00001, 20'h00002, 4'b0000);
    check("arst.add_done", {busy, done}, 2'b01);
    check("arst.add_out", alu_out, 20'h00003);
    check("arst.add_stat", alu_stat, 4'b0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
